// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM encodings shared by the ALU/MDU slice
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_REM  = 4'd13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 shift-add multiplier / restoring divider on magnitudes
// One hi:lo accumulator is shared: multiply shifts right, divide shifts left.
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic                  i_sel_hi,
  input  logic                  i_a_signed,
  input  logic                  i_b_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d, div_q, div_d, sel_hi_q, sel_hi_d;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       sum, rem_sh, diff;
  logic [W-1:0]     step_hi, step_lo, div_val;
  logic [2*W-1:0]   prod;

  always_comb begin
    a_neg   = i_a_signed & i_a[W-1];
    b_neg   = i_b_signed & i_b[W-1];
    a_mag   = a_neg ? -i_a : i_a;
    b_mag   = b_neg ? -i_b : i_b;

    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    rem_sh  = {hi_q, lo_q[W-1]};
    diff    = rem_sh - {1'b0, mcand_q};

    // Divide: a borrow out of the trial subtract means restore and shift in 0.
    if (div_q) begin
      step_hi = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
      step_lo = {lo_q[W-2:0], ~diff[W]};
    end else begin
      step_hi = sum[W:1];
      step_lo = {sum[0], lo_q[W-1:1]};
    end

    prod    = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    div_val = sel_hi_q ? step_hi : step_lo;
    if (div_q) begin
      o_result = neg_q ? -div_val : div_val;
    end else begin
      o_result = sel_hi_q ? prod[2*W-1:W] : prod[W-1:0];
    end
    o_last = (cnt_q == CNT_W'(W - 1));
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    div_d    = div_q;
    sel_hi_d = sel_hi_q;
    if (i_start) begin
      hi_d     = '0;
      mcand_d  = i_is_div ? b_mag : a_mag;
      lo_d     = i_is_div ? a_mag : b_mag;
      cnt_d    = '0;
      neg_d    = (i_is_div & i_sel_hi) ? a_neg : (a_neg ^ b_neg);
      div_d    = i_is_div;
      sel_hi_d = i_sel_hi;
    end else if (i_step) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      div_q    <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      div_q    <= div_d;
      sel_hi_q <= sel_hi_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - single-cycle ALU with iterative MUL/DIV behind a valid/ready handshake
module alu_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3:0]            i_ctrl_ALU_Sel,
  input  logic                  i_ctrl_Unsigned,
  input  logic                  i_ctrl_HSU,
  input  logic [DATA_WIDTH-1:0] i_A,
  input  logic [DATA_WIDTH-1:0] i_B,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_ALU_Result,
  output logic                  o_busy
);

  import alu_pkg::*;

  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       result_q, result_d;
  logic [W-1:0]       alu_res, special_res, mdu_result;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, is_div, div_by_zero, div_ovf, div_special;
  logic               a_signed, b_signed, sel_hi, mdu_start, mdu_last;

  assign o_ready      = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & i_ready));
  assign o_valid      = (state_q == ST_DONE);
  assign o_busy       = (state_q == ST_BUSY);
  assign o_ALU_Result = result_q;
  assign accept       = i_valid & o_ready;

  always_comb begin
    shamt = i_B[SHAMT_W-1:0];
    case (i_ctrl_ALU_Sel)
      OP_ADD:  alu_res = i_A + i_B;
      OP_SUB:  alu_res = i_A - i_B;
      OP_XOR:  alu_res = i_A ^ i_B;
      OP_OR:   alu_res = i_A | i_B;
      OP_AND:  alu_res = i_A & i_B;
      OP_SLL:  alu_res = i_A << shamt;
      OP_SRL:  alu_res = i_A >> shamt;
      OP_SRA:  alu_res = $signed(i_A) >>> shamt;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (i_A < i_B)};
      default: alu_res = '0;
    endcase
  end

  // Zero divisor and signed overflow finish without iterating.
  always_comb begin
    is_div      = (i_ctrl_ALU_Sel == OP_DIV) | (i_ctrl_ALU_Sel == OP_REM);
    sel_hi      = (i_ctrl_ALU_Sel == OP_MULH) | (i_ctrl_ALU_Sel == OP_REM);
    div_by_zero = (i_B == '0);
    div_ovf     = ~i_ctrl_Unsigned & (i_A == {1'b1, {(W-1){1'b0}}}) & (i_B == '1);
    div_special = is_div & (div_by_zero | div_ovf);
    if (div_by_zero) begin
      special_res = sel_hi ? i_A : '1;
    end else begin
      special_res = sel_hi ? '0 : i_A;
    end
    a_signed = is_div ? ~i_ctrl_Unsigned : (i_ctrl_HSU | ~i_ctrl_Unsigned);
    b_signed = is_div ? ~i_ctrl_Unsigned : (~i_ctrl_HSU & ~i_ctrl_Unsigned);
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    mdu_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (!is_mdu_op(i_ctrl_ALU_Sel)) begin
            result_d = alu_res;
            state_d  = ST_DONE;
          end else if (div_special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            mdu_start = 1'b1;
            state_d   = ST_BUSY;
          end
        end else if (state_q == ST_DONE && i_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mdu_last) begin
          result_d = mdu_result;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  mdu_iter #(.DATA_WIDTH(W)) u_mdu_iter (
    .clk        (clk),
    .rst        (rst),
    .i_start    (mdu_start),
    .i_step     (o_busy),
    .i_is_div   (is_div),
    .i_sel_hi   (sel_hi),
    .i_a_signed (a_signed),
    .i_b_signed (b_signed),
    .i_a        (i_A),
    .i_b        (i_B),
    .o_last     (mdu_last),
    .o_result   (mdu_result)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed vector bench for alu_mdu at 32 and 16 bit widths
module tb_alu_mdu;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic        uns;
    logic        hsu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_uns, i_hsu;
  logic [3:0]  i_sel;
  logic [31:0] i_a, i_b, o_res;
  logic        o_ready, o_valid, o_busy;

  logic        v16, u16, h16, r16, rdy16, ov16, busy16;
  logic [3:0]  sel16;
  logic [15:0] a16, b16, res16;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[25];

  always #5 clk = ~clk;

  alu_mdu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ctrl_ALU_Sel(i_sel), .i_ctrl_Unsigned(i_uns), .i_ctrl_HSU(i_hsu),
    .i_A(i_a), .i_B(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_ALU_Result(o_res), .o_busy(o_busy)
  );

  alu_mdu #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .i_valid(v16), .o_ready(rdy16),
    .i_ctrl_ALU_Sel(sel16), .i_ctrl_Unsigned(u16), .i_ctrl_HSU(h16),
    .i_A(a16), .i_B(b16), .o_valid(ov16), .i_ready(r16),
    .o_ALU_Result(res16), .o_busy(busy16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic uns, input logic hsu,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.uns = uns; v.hsu = hsu; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Issue one op from IDLE with i_ready high; latency counts edges after the accept edge.
  task automatic run32(input logic [3:0] op, input logic uns, input logic hsu,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    i_sel = op; i_uns = uns; i_hsu = hsu; i_a = a; i_b = b; i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_a = 32'hDEAD_BEEF; i_b = 32'h0BAD_F00D;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = o_res;
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    sel16 = op; u16 = 1'b0; h16 = 1'b0; a16 = a; b16 = b; v16 = 1'b1; r16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = res16;
  endtask

  initial begin
    logic [31:0] res;
    logic [15:0] res_16;
    int lat;

    vecs[0]  = mk(OP_ADD,  0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    vecs[1]  = mk(OP_SUB,  0, 0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    vecs[2]  = mk(OP_XOR,  0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    vecs[3]  = mk(OP_OR,   0, 0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1);
    vecs[4]  = mk(OP_AND,  0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    vecs[5]  = mk(OP_SLL,  0, 0, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1);
    vecs[6]  = mk(OP_SRL,  0, 0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1);
    vecs[7]  = mk(OP_SRA,  0, 0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1);
    vecs[8]  = mk(OP_SLT,  0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    vecs[9]  = mk(OP_SLTU, 0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    vecs[10] = mk(OP_MUL,  0, 0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
    vecs[11] = mk(OP_MULH, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    vecs[12] = mk(OP_MULH, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    vecs[13] = mk(OP_MULH, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    vecs[14] = mk(OP_MULH, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    vecs[15] = mk(OP_DIV,  0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    vecs[16] = mk(OP_REM,  0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    vecs[17] = mk(OP_DIV,  0, 0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    vecs[18] = mk(OP_REM,  0, 0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1);
    vecs[19] = mk(OP_DIV,  0, 0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    vecs[20] = mk(OP_DIV,  1, 0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33);
    vecs[21] = mk(OP_REM,  1, 0, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 33);
    vecs[22] = mk(OP_REM,  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    vecs[23] = mk(4'd14,   0, 0, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1);
    vecs[24] = mk(4'd15,   1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sel = '0; i_uns = 0; i_hsu = 0;
    i_a = '0; i_b = '0;
    v16 = 1'b0; r16 = 1'b1; sel16 = '0; u16 = 0; h16 = 0; a16 = '0; b16 = '0;

    repeat (3) @(negedge clk);
    chk("reset_o_ready", o_ready, 0);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_busy", o_busy, 0);
    chk("reset_result", o_res, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", o_ready, 1);

    for (int i = 0; i < 25; i++) begin
      run32(vecs[i].op, vecs[i].uns, vecs[i].hsu, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Eight back-to-back ADDs complete on eight consecutive cycles.
    @(negedge clk);
    i_sel = OP_ADD; i_uns = 0; i_hsu = 0; i_a = 0; i_b = 32'd10; i_valid = 1'b1; i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_valid", k), o_valid, 1);
      chk($sformatf("b2b%0d_result", k), o_res, 32'(k - 1 + 10));
      chk($sformatf("b2b%0d_ready", k), o_ready, 1);
      if (k < 8) i_a = 32'(k);
      else i_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_after", o_valid, 0);

    // Result held while the consumer stalls; new requests are refused.
    @(negedge clk);
    i_sel = OP_REM; i_a = 32'hFFFF_FFF9; i_b = 32'd2; i_valid = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_latency", lat, 33);
    i_sel = OP_ADD; i_a = 32'd1; i_b = 32'd1; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), o_valid, 1);
      chk($sformatf("stall%0d_result", k), o_res, 32'hFFFF_FFFF);
      chk($sformatf("stall%0d_ready", k), o_ready, 0);
      @(negedge clk);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", o_valid, 0);

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    i_sel = OP_DIV; i_uns = 0; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk("div_busy_cycle1", o_busy, 1);
    repeat (9) @(negedge clk);
    chk("div_busy_cycle10", o_busy, 1);
    rst = 1'b1;
    #1;
    chk("ready_during_rst", o_ready, 0);
    @(negedge clk);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_result", o_res, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_release", o_ready, 1);
    run32(OP_ADD, 0, 0, 32'd3, 32'd4, res, lat);
    chk("post_rst_add", res, 32'd7);
    chk("post_rst_add_lat", lat, 1);

    // 16-bit instance: shift amount uses only the low four bits.
    run16(OP_SLL, 16'h0001, 16'h0011, res_16, lat);
    chk("w16_sll_result", res_16, 16'h0002);
    chk("w16_sll_latency", lat, 1);
    run16(OP_MUL, 16'h0100, 16'h0100, res_16, lat);
    chk("w16_mul_result", res_16, 16'h0000);
    chk("w16_mul_latency", lat, 17);
    run16(OP_MULH, 16'h0100, 16'h0100, res_16, lat);
    chk("w16_mulh_result", res_16, 16'h0001);
    chk("w16_mulh_latency", lat, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
